// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command driver slice.
// Response bundle packs {overflow, zero, carry, result} like the ALU top.
package alu_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_RESP = S_RESP
    } state_e;

    // Flag bits sit directly above the result field.
    localparam int RSP_FLAG_W   = 3;
    localparam int OFS_RESULT   = 0;
    localparam int OFS_CARRY_UP = 0;
    localparam int OFS_ZERO_UP  = 1;
    localparam int OFS_OVF_UP   = 2;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Command and response valid/ready bundle of the ALU command driver.
// master = command source / response consumer, slave = driver.
interface alu_cmd_driver_if
    import alu_pkg::*;
#(
    parameter int width = 32
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [ALUOP_W-1:0] cmd_op;
    logic [width-1:0]   cmd_a;
    logic [width-1:0]   cmd_b;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [width-1:0]   rsp_result;
    logic               rsp_overflow;
    logic               rsp_zero;
    logic               rsp_carry;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result,
        input  rsp_overflow, rsp_zero, rsp_carry
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result,
        output rsp_overflow, rsp_zero, rsp_carry
    );
endinterface

// File: rtl/alu_lat_timer.sv
// Down-counter measuring the ALU pipeline latency.
// load arms it with LATENCY-1; done is high while the count is zero.
module alu_lat_timer #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

    logic [CW-1:0] cnt_q;

    // Reload on command accept, otherwise count down to zero and stay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/alu_cmd_driver.sv
// Drives one ALU command at a time, waits the ALU latency and
// returns the captured result and flags on a valid/ready port.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int width   = 32,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_driver_if.slave    bus,
    output logic [width-1:0]   alu_R2,
    output logic [width-1:0]   alu_R3,
    output logic [ALUOP_W-1:0] alu_ALUop,
    input  logic [width-1:0]   alu_R0,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    input  logic               alu_carry,
    output logic               busy,
    output logic [CNT_W-1:0]   ovf_count
);
    localparam int RW        = width + RSP_FLAG_W;
    localparam int OFS_CARRY = width + OFS_CARRY_UP;
    localparam int OFS_ZERO  = width + OFS_ZERO_UP;
    localparam int OFS_OVF   = width + OFS_OVF_UP;

    state_e state_q;
    state_e state_d;

    logic          accept;
    logic          capture;
    logic          retire;
    logic          lat_done;
    logic          rsp_valid_q;
    logic [RW-1:0] rsp_q;
    logic [RW-1:0] alu_bundle;

    assign alu_bundle = {alu_overflow, alu_zero, alu_carry, alu_R0};

    alu_lat_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .done  (lat_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake strobes; cmd_ready never depends on cmd_valid.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        retire        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_done) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.cmd_ready = bus.rsp_ready;
                if (bus.rsp_ready) begin
                    retire = 1'b1;
                    if (bus.cmd_valid) begin
                        accept  = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand registers load only on accept and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_R2    <= '0;
            alu_R3    <= '0;
            alu_ALUop <= '0;
        end else if (accept) begin
            alu_R2    <= bus.cmd_a;
            alu_R3    <= bus.cmd_b;
            alu_ALUop <= bus.cmd_op;
        end
    end

    // Response capture and valid flag; held until the consumer retires it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else if (capture) begin
            rsp_q       <= alu_bundle;
            rsp_valid_q <= 1'b1;
        end else if (retire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Saturating count of captured overflow responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (capture && alu_overflow && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_result   = rsp_q[OFS_RESULT +: width];
    assign bus.rsp_carry    = rsp_q[OFS_CARRY];
    assign bus.rsp_zero     = rsp_q[OFS_ZERO];
    assign bus.rsp_overflow = rsp_q[OFS_OVF];
    assign busy             = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver with a registered adder standing in for the ALU.
// Expected responses are queued at command accept and popped on response.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int CW  = 2;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
        logic         carry;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_driver_if #(.width(W)) bus();

    logic [W-1:0]       alu_R2;
    logic [W-1:0]       alu_R3;
    logic [ALUOP_W-1:0] alu_ALUop;
    logic [W-1:0]       alu_R0;
    logic               alu_overflow;
    logic               alu_zero;
    logic               alu_carry;
    logic               busy;
    logic [CW-1:0]      ovf_count;

    alu_cmd_driver #(
        .width   (W),
        .LATENCY (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_R2       (alu_R2),
        .alu_R3       (alu_R3),
        .alu_ALUop    (alu_ALUop),
        .alu_R0       (alu_R0),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .busy         (busy),
        .ovf_count    (ovf_count)
    );

    // Registered adder stub: result valid one edge after operands settle.
    logic [W:0] stub_sum;
    always_comb stub_sum = {1'b0, alu_R2} + {1'b0, alu_R3};
    always_ff @(posedge clk) begin
        alu_R0       <= stub_sum[W-1:0];
        alu_carry    <= stub_sum[W];
        alu_zero     <= (stub_sum[W-1:0] == '0);
        alu_overflow <= (alu_R2[W-1] == alu_R3[W-1])
                     && (stub_sum[W-1] != alu_R2[W-1]);
    end

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [W:0]  s;
        s       = {1'b0, a} + {1'b0, b};
        e.res   = s[W-1:0];
        e.carry = s[W];
        e.zero  = (s[W-1:0] == '0);
        e.ovf   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return e;
    endfunction

    // Offer one command from a negedge; returns at the negedge after accept.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bus.cmd_ready) begin
            errors++;
            $display("FAIL issue_timeout: cmd_ready=%b want 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.rsp_valid;
    endtask

    task automatic retire();
        if (bus.rsp_valid) begin
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.cmd_ready, bus.rsp_valid, busy);
        end
        checks++;
        if (alu_R2 !== '0 || alu_R3 !== '0 || alu_ALUop !== '0
            || ovf_count !== '0 || bus.rsp_result !== '0) begin
            errors++;
            $display("FAIL reset_data: R2=%h R3=%h op=%h cnt=%0d res=%h want 0",
                     alu_R2, alu_R3, alu_ALUop, ovf_count, bus.rsp_result);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b vld=%b want 1 0 0",
                     bus.cmd_ready, busy, bus.rsp_valid);
        end
    endtask

    task automatic test_basic_add();
        exp_t e;
        issue(3'd0, 32'd5, 32'd3);
        checks++;
        if (alu_R2 !== 32'd5 || alu_R3 !== 32'd3 || busy !== 1'b1
            || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_drive: R2=%0d R3=%0d busy=%b rdy=%b want 5 3 1 0",
                     alu_R2, alu_R3, busy, bus.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: rsp_valid=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL basic_latency: rsp_valid=%b want 1", bus.rsp_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.rsp_result !== 32'd8 || bus.rsp_zero !== 1'b0
                || bus.rsp_carry !== 1'b0 || e.res !== bus.rsp_result) begin
                errors++;
                $display("FAIL basic_rsp: res=%0d z=%b c=%b want 8 0 0",
                         bus.rsp_result, bus.rsp_zero, bus.rsp_carry);
            end
        end
        retire();
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_retire: vld=%b busy=%b want 0 0",
                     bus.rsp_valid, busy);
        end
    endtask

    task automatic test_flags();
        exp_t e;
        bit   ok;
        issue(3'd1, 32'h7FFF_FFFF, 32'd1);
        wait_rsp(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL ovf_timeout: rsp_valid=%b want 1", bus.rsp_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.rsp_overflow !== 1'b1 || bus.rsp_result !== 32'h8000_0000
                || ovf_count !== 2'd1 || e.ovf !== bus.rsp_overflow) begin
                errors++;
                $display("FAIL ovf_rsp: ovf=%b res=%h cnt=%0d want 1 80000000 1",
                         bus.rsp_overflow, bus.rsp_result, ovf_count);
            end
        end
        retire();
        issue(3'd1, 32'hFFFF_FFFF, 32'd1);
        wait_rsp(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL zc_timeout: rsp_valid=%b want 1", bus.rsp_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.rsp_zero !== 1'b1 || bus.rsp_carry !== 1'b1
                || bus.rsp_overflow !== 1'b0 || bus.rsp_result !== e.res
                || ovf_count !== 2'd1) begin
                errors++;
                $display("FAIL zc_rsp: z=%b c=%b o=%b res=%h cnt=%0d want 1 1 0 0 1",
                         bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow,
                         bus.rsp_result, ovf_count);
            end
        end
        retire();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        bit           ok;
        logic [W+2:0] snap;
        issue(3'd2, 32'd10, 32'd20);
        wait_rsp(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_timeout: rsp_valid=%b want 1", bus.rsp_valid);
        end
        snap = {bus.rsp_overflow, bus.rsp_zero, bus.rsp_carry, bus.rsp_result};
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.cmd_a = 32'(1000 + i);
            bus.cmd_b = 32'(i);
            @(negedge clk);
            checks++;
            if ({bus.rsp_overflow, bus.rsp_zero, bus.rsp_carry, bus.rsp_result} !== snap
                || bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1
                || alu_R2 !== 32'd10) begin
                errors++;
                $display("FAIL hold_cycle%0d: res=%h rdy=%b vld=%b R2=%0d want %h 0 1 10",
                         i, bus.rsp_result, bus.cmd_ready, bus.rsp_valid,
                         alu_R2, snap[W-1:0]);
            end
        end
        bus.cmd_a     = 32'd100;
        bus.cmd_b     = 32'd200;
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_passthru: cmd_ready=%b want 1", bus.cmd_ready);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (snap !== {e.ovf, e.zero, e.carry, e.res} || e.res !== 32'd30) begin
                errors++;
                $display("FAIL hold_rsp: got %h want %h",
                         snap, {e.ovf, e.zero, e.carry, e.res});
            end
        end
        @(posedge clk);
        sb.push_back(model(32'd100, 32'd200));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || busy !== 1'b1
            || alu_R2 !== 32'd100 || alu_R3 !== 32'd200) begin
            errors++;
            $display("FAIL b2b_accept: vld=%b busy=%b R2=%0d R3=%0d want 0 1 100 200",
                     bus.rsp_valid, busy, alu_R2, alu_R3);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_early: rsp_valid=%b want 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_latency: rsp_valid=%b want 1", bus.rsp_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.rsp_result !== 32'd300 || bus.rsp_result !== e.res) begin
                errors++;
                $display("FAIL b2b_rsp: res=%0d want 300", bus.rsp_result);
            end
        end
        retire();
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   ok;
        int   seen = 0;
        issue(3'd0, 32'd1, 32'd2);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0
            || alu_R2 !== '0 || ovf_count !== '0) begin
            errors++;
            $display("FAIL abort_reset: rdy=%b vld=%b busy=%b R2=%h cnt=%0d",
                     bus.cmd_ready, bus.rsp_valid, busy, alu_R2, ovf_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_norsp: rsp_valid cycles=%0d want 0", seen);
        end
        issue(3'd0, 32'd4, 32'd4);
        wait_rsp(ok);
        checks++;
        if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL abort_next_timeout: rsp_valid=%b want 1", bus.rsp_valid);
        end else begin
            e = sb.pop_front();
            checks++;
            if (bus.rsp_result !== 32'd8 || bus.rsp_result !== e.res) begin
                errors++;
                $display("FAIL abort_next_rsp: res=%0d want 8", bus.rsp_result);
            end
        end
        retire();
    endtask

    task automatic test_saturation();
        exp_t        e;
        bit          ok;
        logic [CW-1:0] exp_cnt = '0;
        checks++;
        if (ovf_count !== '0) begin
            errors++;
            $display("FAIL sat_start: cnt=%0d want 0", ovf_count);
        end
        for (int i = 0; i < 5; i++) begin
            issue(3'd0, 32'h7FFF_FFFF, 32'(i + 1));
            if (exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
            wait_rsp(ok);
            checks++;
            if (!ok || sb.size() == 0) begin
                errors++;
                $display("FAIL sat_timeout%0d: rsp_valid=%b want 1", i, bus.rsp_valid);
            end else begin
                e = sb.pop_front();
                checks++;
                if (ovf_count !== exp_cnt || bus.rsp_overflow !== e.ovf
                    || bus.rsp_result !== e.res) begin
                    errors++;
                    $display("FAIL sat_op%0d: cnt=%0d ovf=%b res=%h want %0d %b %h",
                             i, ovf_count, bus.rsp_overflow, bus.rsp_result,
                             exp_cnt, e.ovf, e.res);
                end
            end
            retire();
        end
        checks++;
        if (ovf_count !== 2'd3) begin
            errors++;
            $display("FAIL sat_final: cnt=%0d want 3", ovf_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_flags();
        test_back_to_back();
        test_reset_abort();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
